// File: rtl/mem_pkg.sv
// Shared definitions for the MEM-stage data-memory access unit:
// access size codes, FSM state encoding and the bus timeout default.
package mem_pkg;

  localparam int DATA_W          = 32;
  localparam int TIMEOUT_DEFAULT = 255;

  localparam logic [1:0] MS_BYTE = 2'd0;
  localparam logic [1:0] MS_HALF = 2'd1;
  localparam logic [1:0] MS_WORD = 2'd2;
  localparam logic [1:0] MS_RSVD = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_RWAIT = 2'd2
  } state_t;

  // Halfwords need a[0]==0, words need a[1:0]==0; bytes are always aligned.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    logic bad;
    bad = 1'b0;
    if (size == MS_HALF) bad = off[0];
    if (size == MS_WORD) bad = |off;
    return bad;
  endfunction

endpackage

// File: rtl/mem_align.sv
// Lane steering for the data-memory bus: byte enables and replicated store
// data on the write side, lane extraction plus sign/zero extension on loads.
module mem_align
  import mem_pkg::*;
(
  input  logic [1:0]        wsize,
  input  logic [1:0]        woff,
  input  logic [DATA_W-1:0] sdata,
  output logic [3:0]        be,
  output logic [DATA_W-1:0] wdata,
  input  logic [1:0]        rsize,
  input  logic [1:0]        roff,
  input  logic              rsigned,
  input  logic [DATA_W-1:0] rdata,
  output logic [DATA_W-1:0] ldata
);

  function automatic logic [31:0] ext8(input logic [7:0] b, input logic sgn);
    return {{24{sgn & b[7]}}, b};
  endfunction

  function automatic logic [31:0] ext16(input logic [15:0] h, input logic sgn);
    return {{16{sgn & h[15]}}, h};
  endfunction

  logic [7:0]  lane8;
  logic [15:0] lane16;

  always_comb begin
    be    = 4'b0000;
    wdata = '0;
    case (wsize)
      MS_BYTE: begin
        be    = 4'b0001 << woff;
        wdata = {4{sdata[7:0]}};
      end
      MS_HALF: begin
        be    = woff[1] ? 4'b1100 : 4'b0011;
        wdata = {2{sdata[15:0]}};
      end
      MS_WORD: begin
        be    = 4'b1111;
        wdata = sdata;
      end
      default: ;
    endcase
  end

  always_comb begin
    lane8 = rdata[7:0];
    case (roff)
      2'd1:    lane8 = rdata[15:8];
      2'd2:    lane8 = rdata[23:16];
      2'd3:    lane8 = rdata[31:24];
      default: lane8 = rdata[7:0];
    endcase
    lane16 = roff[1] ? rdata[31:16] : rdata[15:0];
    case (rsize)
      MS_BYTE: ldata = ext8(lane8, rsigned);
      MS_HALF: ldata = ext16(lane16, rsigned);
      default: ldata = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access unit: issues byte/half/word loads and stores
// over a valid/ready bus, stalls the pipeline while busy, returns extended loads.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [1:0]  MemSize,
  input  logic        MemSigned,
  input  logic [31:0] ALUResult,
  input  logic [31:0] StoreData,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ready,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] LoadData,
  output logic        load_done,
  output logic        MemStall,
  output logic        addr_err,
  output logic        bus_err
);

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYC - 1);

  state_t state, state_nxt;

  logic [7:0]        cnt;
  logic [1:0]        size_q;
  logic [1:0]        off_q;
  logic              signed_q;

  logic              req_ok;
  logic              mis;
  logic              accept;
  logic              mis_acc;
  logic              rd_done;
  logic              tmo_hit;
  logic [3:0]        be_c;
  logic [DATA_W-1:0] wdata_c;
  logic [DATA_W-1:0] ldata_c;

  // Both MemRead and MemWrite, or the reserved size, is a silent no-op.
  assign req_ok  = in_valid & (MemRead ^ MemWrite) & (MemSize != MS_RSVD);
  assign mis     = misaligned(MemSize, ALUResult[1:0]);
  assign accept  = (state == ST_IDLE) & req_ok & ~mis;
  assign mis_acc = (state == ST_IDLE) & req_ok & mis;

  mem_align u_align (
    .wsize   (MemSize),
    .woff    (ALUResult[1:0]),
    .sdata   (StoreData),
    .be      (be_c),
    .wdata   (wdata_c),
    .rsize   (size_q),
    .roff    (off_q),
    .rsigned (signed_q),
    .rdata   (dmem_rdata),
    .ldata   (ldata_c)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    rd_done   = 1'b0;
    tmo_hit   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) state_nxt = ST_REQ;
      end
      ST_REQ: begin
        if (dmem_ready) begin
          if (dmem_we) begin
            state_nxt = ST_IDLE;
          end else if (dmem_rvalid) begin
            rd_done   = 1'b1;
            state_nxt = ST_IDLE;
          end else begin
            state_nxt = ST_RWAIT;
          end
        end else if (cnt == TMO_LAST) begin
          tmo_hit   = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      ST_RWAIT: begin
        if (dmem_rvalid) begin
          rd_done   = 1'b1;
          state_nxt = ST_IDLE;
        end else if (cnt == TMO_LAST) begin
          tmo_hit   = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    MemStall = (state != ST_IDLE) | accept;
  end

  // ---- registered bus request, latched access attributes, load result ----
  always_ff @(posedge clk) begin
    if (reset) begin
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      dmem_be    <= 4'b0000;
      LoadData   <= '0;
      load_done  <= 1'b0;
      addr_err   <= 1'b0;
      bus_err    <= 1'b0;
      cnt        <= 8'd0;
      size_q     <= MS_BYTE;
      off_q      <= 2'd0;
      signed_q   <= 1'b0;
    end else begin
      load_done <= rd_done;
      addr_err  <= mis_acc;
      bus_err   <= tmo_hit;

      if (accept) begin
        dmem_req   <= 1'b1;
        dmem_we    <= MemWrite;
        dmem_addr  <= {ALUResult[31:2], 2'b00};
        dmem_be    <= be_c;
        dmem_wdata <= wdata_c;
        size_q     <= MemSize;
        off_q      <= ALUResult[1:0];
        signed_q   <= MemSigned;
        cnt        <= 8'd0;
      end else if (state != ST_IDLE) begin
        // Request is only live while in REQ; any exit from REQ retires it.
        if (state_nxt != ST_REQ) begin
          dmem_req <= 1'b0;
        end
        if (state_nxt == ST_IDLE) begin
          dmem_we <= 1'b0;
        end
        cnt <= (state_nxt == state) ? cnt + 8'd1 : 8'd0;
      end

      if (rd_done) begin
        LoadData <= ldata_c;
      end
    end
  end

endmodule
